// File: rtl/mb_rsp_tx.sv
`default_nettype none
// ============================================================================
// Module   : mb_rsp_tx
// Brief    : Modbus RTU slave response sequencer. It waits for the inter-frame
//            gap, then streams the echo or exception frame with a serial
//            CRC-16/Modbus to a byte UART. Define MB_EXC_RSP_EN to enable
//            exception responses.
// Revision : 1.0
// ============================================================================
module mb_rsp_tx #(
    parameter logic [7:0]  SLAVE_ADDR = 8'h01,
    parameter int unsigned GAP_CYCLES = 10000,
    parameter logic [15:0] CRC_INIT   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [7:0]  req_addr,
    input  logic [7:0]  req_func,
    input  logic [15:0] req_reg,
    input  logic [15:0] req_num,
    input  logic        crc_err,
    input  logic        tx_done,
    output logic        send_en,
    output logic [7:0]  data_byte,
    output logic        busy,
    output logic        rsp_done,
    output logic        req_drop
);
    localparam logic [15:0]     c_POLY     = 16'hA001;
    localparam int unsigned     c_GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GAP  = 3'd1,
        S_LOAD = 3'd2,
        S_SEND = 3'd3,
        S_WAIT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [7:0]     r_addr, r_func;
    logic [15:0]    r_reg, r_num;
    logic [c_GW-1:0] r_gap_cnt;
    logic [2:0]     r_idx;
    logic [15:0]    r_crc;
    logic [7:0]     r_crc_sh;
    logic [3:0]     r_crc_cnt;
    logic [7:0]     r_data_byte;
    logic           r_req_drop;

    logic           w_func_ok, w_accept, w_exc;
    logic [2:0]     w_last_idx, w_crc_lo_idx;
    logic [7:0]     w_byte;

    assign w_func_ok = (req_func == 8'h06) || (req_func == 8'h10);

`ifdef MB_EXC_RSP_EN
    logic r_exc;

    assign w_accept = (r_state == S_IDLE) && req_valid && !crc_err && (req_addr == SLAVE_ADDR);
    assign w_exc    = r_exc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc <= 1'b0;
        end else if (w_accept) begin
            r_exc <= !w_func_ok;
        end
    end
`else
    assign w_accept = (r_state == S_IDLE) && req_valid && !crc_err &&
                      (req_addr == SLAVE_ADDR) && w_func_ok;
    assign w_exc    = 1'b0;
`endif

    assign w_last_idx   = w_exc ? 3'd4 : 3'd7;
    assign w_crc_lo_idx = w_exc ? 3'd3 : 3'd6;

    always_comb begin
        w_byte = 8'h00;
        if (w_exc) begin
            case (r_idx)
                3'd0:    w_byte = r_addr;
                3'd1:    w_byte = r_func | 8'h80;
                3'd2:    w_byte = 8'h01;
                3'd3:    w_byte = r_crc[7:0];
                default: w_byte = r_crc[15:8];
            endcase
        end else begin
            case (r_idx)
                3'd0:    w_byte = r_addr;
                3'd1:    w_byte = r_func;
                3'd2:    w_byte = r_reg[15:8];
                3'd3:    w_byte = r_reg[7:0];
                3'd4:    w_byte = r_num[15:8];
                3'd5:    w_byte = r_num[7:0];
                3'd6:    w_byte = r_crc[7:0];
                default: w_byte = r_crc[15:8];
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_GAP;
            S_GAP:  if (r_gap_cnt == c_GAP_LAST) w_state_nxt = S_LOAD;
            // Stall loading until the serial CRC has consumed the previous byte
            S_LOAD: if (r_crc_cnt == 4'd0) w_state_nxt = S_SEND;
            S_SEND: w_state_nxt = S_WAIT;
            S_WAIT: if (tx_done) w_state_nxt = (r_idx == w_last_idx) ? S_DONE : S_LOAD;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= 8'h00;
            r_func      <= 8'h00;
            r_reg       <= 16'h0000;
            r_num       <= 16'h0000;
            r_gap_cnt   <= '0;
            r_idx       <= 3'd0;
            r_crc       <= CRC_INIT;
            r_crc_sh    <= 8'h00;
            r_crc_cnt   <= 4'd0;
            r_data_byte <= 8'h00;
            r_req_drop  <= 1'b0;
        end else begin
            r_req_drop <= req_valid && (r_state != S_IDLE);
            if (w_accept) begin
                r_addr    <= req_addr;
                r_func    <= req_func;
                r_reg     <= req_reg;
                r_num     <= req_num;
                r_gap_cnt <= '0;
                r_idx     <= 3'd0;
                r_crc     <= CRC_INIT;
                r_crc_cnt <= 4'd0;
            end
            if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
            if (r_state == S_LOAD && r_crc_cnt == 4'd0) r_data_byte <= w_byte;
            // Only payload bytes feed the CRC; the two CRC bytes do not
            if (r_state == S_SEND && r_idx < w_crc_lo_idx) begin
                r_crc_sh  <= r_data_byte;
                r_crc_cnt <= 4'd8;
            end else if (r_crc_cnt != 4'd0) begin
                r_crc     <= (r_crc >> 1) ^ ((r_crc[0] ^ r_crc_sh[0]) ? c_POLY : 16'h0000);
                r_crc_sh  <= r_crc_sh >> 1;
                r_crc_cnt <= r_crc_cnt - 4'd1;
            end
            if (r_state == S_WAIT && tx_done && r_idx != w_last_idx) r_idx <= r_idx + 3'd1;
        end
    end

    assign send_en   = (r_state == S_SEND);
    assign data_byte = r_data_byte;
    assign busy      = (r_state == S_GAP) || (r_state == S_LOAD) ||
                       (r_state == S_SEND) || (r_state == S_WAIT);
    assign rsp_done  = (r_state == S_DONE);
    assign req_drop  = r_req_drop;

endmodule
`default_nettype wire

// File: tb/tb_mb_rsp_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mb_rsp_tx
// Brief    : Directed and randomized checks of mb_rsp_tx against a
//            frame/CRC reference model.
// Revision : 1.0
// ============================================================================
module tb_mb_rsp_tx;
    localparam int          GAP    = 20;
    localparam logic [7:0]  SLAVE  = 8'h01;
    localparam int          BUDGET = 3000;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [7:0]  req_func = 8'h00;
    logic [15:0] req_reg = 16'h0000;
    logic [15:0] req_num = 16'h0000;
    logic        crc_err = 1'b0;
    logic        tx_done;
    logic        send_en, busy, rsp_done, req_drop;
    logic [7:0]  data_byte;

    int      errors = 0;
    int      checks = 0;
    int      cyc = 0;
    int      first_send = -1;
    int      rsp_cnt = 0;
    int      pend = 0;
    bit      busy_seen = 1'b0;
    bit      stray = 1'b0;
    logic [7:0] held = 8'h00;
    byte_q_t cap_q;

    mb_rsp_tx #(
        .SLAVE_ADDR (SLAVE),
        .GAP_CYCLES (GAP),
        .CRC_INIT   (16'hFFFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_func  (req_func),
        .req_reg   (req_reg),
        .req_num   (req_num),
        .crc_err   (crc_err),
        .tx_done   (tx_done),
        .send_en   (send_en),
        .data_byte (data_byte),
        .busy      (busy),
        .rsp_done  (rsp_done),
        .req_drop  (req_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input byte_q_t q);
        logic [15:0] c = 16'hFFFF;
        foreach (q[i]) begin
            c = c ^ {8'h00, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Expected response bytes for a request; empty when no response is due
    function automatic byte_q_t model(input logic [7:0] a, input logic [7:0] f,
                                      input logic [15:0] r, input logic [15:0] n, input bit ce);
        byte_q_t q = {};
        logic [15:0] c;
        if (ce || a != SLAVE) return q;
        if (f == 8'h06 || f == 8'h10) q = {a, f, r[15:8], r[7:0], n[15:8], n[7:0]};
`ifdef MB_EXC_RSP_EN
        else q = {a, f | 8'h80, 8'h01};
`endif
        if (q.size() == 0) return q;
        c = crc16(q);
        q.push_back(c[7:0]);
        q.push_back(c[15:8]);
        return q;
    endfunction

    always @(negedge clk) begin
        if (send_en) begin
            cap_q.push_back(data_byte);
            if (first_send < 0) first_send = cyc;
        end
        if (rsp_done) rsp_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    // UART model: tx_done 10..20 cycles after each send_en, plus optional stray pulse
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (rst) begin
                pend = 0;
            end else if (pend > 0) begin
                chk("send_en_before_tx_done", {31'd0, send_en}, 32'd0);
                chk("data_byte_held", {24'd0, data_byte}, {24'd0, held});
                pend--;
                if (pend == 0) tx_done = 1'b1;
            end else if (send_en) begin
                pend = $urandom_range(20, 10);
                held = data_byte;
            end else if (stray) begin
                tx_done = 1'b1;
                stray = 1'b0;
            end
        end
    end

    task automatic pulse_req(input logic [7:0] a, input logic [7:0] f, input logic [15:0] r,
                             input logic [15:0] n, input bit ce, output int t0);
        req_addr = a; req_func = f; req_reg = r; req_num = n; crc_err = ce;
        req_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        crc_err = 1'b0;
    endtask

    task automatic send_req(input logic [7:0] a, input logic [7:0] f, input logic [15:0] r,
                            input logic [15:0] n, input bit ce, output int t0);
        cap_q = {};
        first_send = -1;
        rsp_cnt = 0;
        busy_seen = 1'b0;
        pulse_req(a, f, r, n, ce, t0);
    endtask

    task automatic expect_frame(input string tag, input byte_q_t exp, input int t0);
        int n = 0;
        while (rsp_cnt == 0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, {31'd0, n < BUDGET}, 32'd1);
        @(negedge clk);
        chk({tag, "_len"}, cap_q.size(), exp.size());
        foreach (exp[i]) chk($sformatf("%s_b%0d", tag, i),
                             (i < cap_q.size()) ? {24'd0, cap_q[i]} : 32'hFFFF_FFFF, {24'd0, exp[i]});
        chk({tag, "_latency"}, first_send - t0, GAP + 2);
        chk({tag, "_rsp_done"}, rsp_cnt, 1);
        chk({tag, "_busy_seen"}, {31'd0, busy_seen}, 32'd1);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        repeat (cycles) @(negedge clk);
        chk({tag, "_no_send"}, cap_q.size(), 0);
        chk({tag, "_no_busy"}, {31'd0, busy_seen}, 32'd0);
    endtask

    initial begin
        int          t0, t1, n;
        byte_q_t     exp;
        logic [7:0]  a, f;
        logic [15:0] r, v;
        bit          ce;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_send_en", {31'd0, send_en}, 32'd0);
        chk("rst_data_byte", {24'd0, data_byte}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_done", {31'd0, rsp_done}, 32'd0);
        chk("rst_req_drop", {31'd0, req_drop}, 32'd0);

        send_req(8'h01, 8'h10, 16'h0000, 16'h0002, 1'b0, t0);
        expect_frame("wr_multi", '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'h41, 8'hC8}, t0);

        send_req(8'h01, 8'h06, 16'h0001, 16'h0003, 1'b0, t0);
        stray = 1'b1;
        expect_frame("wr_single", '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B}, t0);

        send_req(8'h01, 8'h06, 16'h0001, 16'h0003, 1'b1, t0);
        expect_silence("filt_crc", GAP + 30);
        send_req(8'h00, 8'h06, 16'h0001, 16'h0003, 1'b0, t0);
        expect_silence("filt_bcast", GAP + 30);
        send_req(8'h02, 8'h06, 16'h0001, 16'h0003, 1'b0, t0);
        expect_silence("filt_addr", GAP + 30);

        send_req(8'h01, 8'h03, 16'h0000, 16'h0001, 1'b0, t0);
`ifdef MB_EXC_RSP_EN
        expect_frame("exc", '{8'h01, 8'h83, 8'h01, 8'h80, 8'hF0}, t0);
`else
        expect_silence("exc_off", GAP + 30);
`endif

        // Overlapping request during byte 3 is dropped; frame stays intact
        send_req(8'h01, 8'h10, 16'h1234, 16'h00A5, 1'b0, t0);
        n = 0;
        while (cap_q.size() < 4 && n < BUDGET) begin @(negedge clk); n++; end
        chk("ovl_reach", {31'd0, n < BUDGET}, 32'd1);
        pulse_req(8'h01, 8'h06, 16'hFFFF, 16'hFFFF, 1'b0, t1);
        chk("ovl_drop_pulse", {31'd0, req_drop}, 32'd1);
        @(negedge clk);
        chk("ovl_drop_end", {31'd0, req_drop}, 32'd0);
        expect_frame("ovl", model(8'h01, 8'h10, 16'h1234, 16'h00A5, 1'b0), t0);

        // req_valid together with the final tx_done is dropped too
        send_req(8'h01, 8'h06, 16'hBEEF, 16'h0102, 1'b0, t0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(tx_done && cap_q.size() == 8) && n < BUDGET);
        chk("sim_reach", {31'd0, n < BUDGET}, 32'd1);
        pulse_req(8'h01, 8'h10, 16'h0000, 16'h0001, 1'b0, t1);
        chk("sim_drop", {31'd0, req_drop}, 32'd1);
        @(negedge clk);
        chk("sim_rsp_done", rsp_cnt, 1);
        cap_q = {};
        busy_seen = 1'b0;
        expect_silence("sim_after", GAP + 30);

        // Reset during byte 5 aborts the frame
        send_req(8'h01, 8'h10, 16'h5555, 16'hAAAA, 1'b0, t0);
        n = 0;
        while (cap_q.size() < 5 && n < BUDGET) begin @(negedge clk); n++; end
        chk("rst_reach", {31'd0, n < BUDGET}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_send_en", {31'd0, send_en}, 32'd0);
        chk("mrst_data_byte", {24'd0, data_byte}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_rsp_done", {31'd0, rsp_done}, 32'd0);
        chk("mrst_req_drop", {31'd0, req_drop}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cap_q = {};
        busy_seen = 1'b0;
        rsp_cnt = 0;
        expect_silence("mrst_after", 100);
        chk("mrst_no_done", rsp_cnt, 0);
        send_req(8'h01, 8'h06, 16'h0001, 16'h0003, 1'b0, t0);
        expect_frame("post_rst", '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B}, t0);

        for (int k = 0; k < 10; k++) begin
            case ($urandom_range(3, 0))
                0, 1:    a = SLAVE;
                2:       a = 8'h00;
                default: a = 8'($urandom);
            endcase
            case ($urandom_range(3, 0))
                0:       f = 8'h06;
                1:       f = 8'h10;
                2:       f = 8'h03;
                default: f = 8'($urandom);
            endcase
            r  = 16'($urandom);
            v  = 16'($urandom);
            ce = ($urandom_range(3, 0) == 0);
            exp = model(a, f, r, v, ce);
            send_req(a, f, r, v, ce, t0);
            if (exp.size() == 0) expect_silence($sformatf("rnd%0d", k), GAP + 30);
            else                 expect_frame($sformatf("rnd%0d", k), exp, t0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
